// File: rtl/ldst_io_pkg.sv
// Shared definitions for the LDST IO-bus peripherals: transmitter state
// encoding, register offsets and STATUS bit positions.
package ldst_io_pkg;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

    // Register offsets from BASE_ADDRESS; REG_COUNT is the decoded window size.
    localparam logic [7:0] REG_TXDATA  = 8'd0;
    localparam logic [7:0] REG_STATUS  = 8'd1;
    localparam logic [7:0] REG_DIVISOR = 8'd2;
    localparam logic [7:0] REG_COUNT   = 8'd3;

    // STATUS bit positions.
    localparam int STATUS_EMPTY    = 0;
    localparam int STATUS_FULL     = 1;
    localparam int STATUS_BUSY     = 2;
    localparam int STATUS_OVERFLOW = 3;

    // Assemble the STATUS read word; unused upper bits read as zero.
    function automatic logic [7:0] status_word(input logic overflow,
                                               input logic busy,
                                               input logic full,
                                               input logic empty);
        logic [7:0] w;
        w                  = 8'h00;
        w[STATUS_OVERFLOW] = overflow;
        w[STATUS_BUSY]     = busy;
        w[STATUS_FULL]     = full;
        w[STATUS_EMPTY]    = empty;
        return w;
    endfunction

endpackage

// File: rtl/ldst_sync_fifo.sv
// Small synchronous FIFO with read/write pointers and an occupancy count.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle (the freed slot is reused). DEPTH must be a power of two >= 2.
module ldst_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import ldst_io_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Accept pops only with data present; accept pushes when space exists or a pop frees a slot.
    always_comb begin
        pop_ok_s  = pop && (count_r != {(AW+1){1'b0}});
        push_ok_s = push && ((count_r != DEPTH_COUNT) || pop_ok_s);
    end

    // Storage array; no reset needed since contents are only read behind the count.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == DEPTH_COUNT);
    assign empty    = (count_r == {(AW+1){1'b0}});
    assign count    = count_r;

endmodule

// File: rtl/ldst_io_uart_tx.sv
// IO-bus UART transmitter: bus writes to TXDATA are queued and sent as 8N1
// frames, LSB first, with a programmable bit period of divisor+1 clocks.
// STATUS and DIVISOR are readable combinationally over the same bus.
module ldst_io_uart_tx #(
    parameter logic [7:0] BASE_ADDRESS    = 8'h08,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [7:0] DEFAULT_DIVISOR = 8'd15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clock_enable,
    input  logic [7:0] io_bus_address,
    input  logic [7:0] io_bus_data_out,
    input  logic       io_bus_out,
    input  logic       io_bus_in,
    output logic [7:0] io_read_data,
    output logic       uart_tx
);
    import ldst_io_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]       offset_s;
    logic             hit_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             push_s;
    logic             overflow_clr_s;
    logic             divisor_wr_s;
    logic             overflow_set_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [7:0]       fifo_data_s;
    logic             busy_s;
    logic             bit_end_s;

    tx_state_t        state_r;
    tx_state_t        state_nx_s;
    logic [7:0]       baud_r;
    logic [7:0]       baud_nx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nx_s;
    logic [2:0]       index_r;
    logic [2:0]       index_nx_s;
    logic             tx_r;
    logic             tx_nx_s;
    logic [7:0]       divisor_r;
    logic             overflow_r;

    ldst_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (io_bus_data_out),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Address decode; the offset subtraction also handles a window wrapping past 8'hFF.
    always_comb begin
        offset_s       = io_bus_address - BASE_ADDRESS;
        hit_s          = (offset_s < REG_COUNT);
        wr_en_s        = clock_enable & io_bus_out & hit_s;
        rd_en_s        = io_bus_in & hit_s;
        push_s         = wr_en_s & (offset_s == REG_TXDATA);
        overflow_clr_s = wr_en_s & (offset_s == REG_STATUS) & io_bus_data_out[STATUS_OVERFLOW];
        divisor_wr_s   = wr_en_s & (offset_s == REG_DIVISOR);
        overflow_set_s = push_s & (fifo_count_s == FULL_COUNT) & ~pop_s;
        busy_s         = (state_r != ST_IDLE);
    end

    // Combinational read mux; zero whenever this block is not being read.
    always_comb begin
        io_read_data = 8'h00;
        if (rd_en_s) begin
            case (offset_s)
                REG_STATUS:  io_read_data = status_word(overflow_r, busy_s, fifo_full_s, fifo_empty_s);
                REG_DIVISOR: io_read_data = divisor_r;
                default:     io_read_data = 8'h00;
            endcase
        end else begin
            io_read_data = 8'h00;
        end
    end

    // Divisor and sticky overflow registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            divisor_r  <= DEFAULT_DIVISOR;
            overflow_r <= 1'b0;
        end else begin
            if (divisor_wr_s) begin
                divisor_r <= io_bus_data_out;
            end
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Transmit sequencing; the line level is computed for the next state so uart_tx stays registered.
    always_comb begin
        state_nx_s = state_r;
        baud_nx_s  = baud_r;
        shift_nx_s = shift_r;
        index_nx_s = index_r;
        tx_nx_s    = tx_r;
        pop_s      = 1'b0;
        bit_end_s  = (baud_r == 8'd0);
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_nx_s = fifo_data_s;
                    baud_nx_s  = divisor_r;
                    state_nx_s = ST_START;
                    tx_nx_s    = 1'b0;
                end else begin
                    tx_nx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nx_s = ST_DATA;
                    index_nx_s = 3'd0;
                    baud_nx_s  = divisor_r;
                    tx_nx_s    = shift_r[0];
                end else begin
                    baud_nx_s  = baud_r - 8'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_nx_s = divisor_r;
                    if (index_r == 3'd7) begin
                        state_nx_s = ST_STOP;
                        tx_nx_s    = 1'b1;
                    end else begin
                        shift_nx_s = {1'b0, shift_r[7:1]};
                        index_nx_s = index_r + 3'd1;
                        tx_nx_s    = shift_r[1];
                    end
                end else begin
                    baud_nx_s = baud_r - 8'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_nx_s = ST_IDLE;
                    tx_nx_s    = 1'b1;
                end else begin
                    baud_nx_s  = baud_r - 8'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                tx_nx_s    = 1'b1;
            end
        endcase
    end

    // Transmitter state registers; reset drops any frame in progress and idles the line high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            baud_r  <= 8'd0;
            shift_r <= 8'd0;
            index_r <= 3'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            baud_r  <= baud_nx_s;
            shift_r <= shift_nx_s;
            index_r <= index_nx_s;
            tx_r    <= tx_nx_s;
        end
    end

    assign uart_tx = tx_r;

endmodule

// File: tb/tb_ldst_io_uart_tx.sv
// Self-checking bench for ldst_io_uart_tx. A frame-level model (byte queue,
// 10-bit frame image, per-bit durations) predicts uart_tx and io_read_data
// every cycle; directed scenarios add literal expectations.
module tb_ldst_io_uart_tx;

    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE  = 8'h08;

    logic       clock;
    logic       reset_n;
    logic       clock_enable;
    logic [7:0] io_bus_address;
    logic [7:0] io_bus_data_out;
    logic       io_bus_out;
    logic       io_bus_in;
    logic [7:0] io_read_data;
    logic       uart_tx;

    int total = 0;
    int bad   = 0;

    ldst_io_uart_tx #(
        .BASE_ADDRESS    (8'h08),
        .FIFO_DEPTH      (4),
        .DEFAULT_DIVISOR (8'd15)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .clock_enable    (clock_enable),
        .io_bus_address  (io_bus_address),
        .io_bus_data_out (io_bus_data_out),
        .io_bus_out      (io_bus_out),
        .io_bus_in       (io_bus_in),
        .io_read_data    (io_read_data),
        .uart_tx         (uart_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    logic [7:0] m_div;
    logic       m_ovf;
    bit         m_active;
    logic [9:0] m_frame;
    int         m_bitno;
    int         m_left;
    logic       m_line;
    bit         m_valid = 1'b0;

    task automatic model_step();
        logic [7:0] off;
        logic [7:0] b;
        off = io_bus_address - BASE;
        if (!reset_n) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_div    = 8'd15;
            m_active = 1'b0;
            m_line   = 1'b1;
            m_valid  = 1'b1;
        end else begin
            if (m_active) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_bitno = m_bitno + 1;
                    if (m_bitno == 10) begin
                        m_active = 1'b0;
                        m_line   = 1'b1;
                    end else begin
                        m_left = int'(m_div) + 1;
                        m_line = m_frame[m_bitno];
                    end
                end
            end else if (mq.size() > 0) begin
                b        = mq.pop_front();
                m_frame  = {1'b1, b, 1'b0};
                m_active = 1'b1;
                m_bitno  = 0;
                m_left   = int'(m_div) + 1;
                m_line   = 1'b0;
            end
            if (clock_enable === 1'b1 && io_bus_out === 1'b1 && off < 8'd3) begin
                if (off == 8'd0) begin
                    if (mq.size() < DEPTH) mq.push_back(io_bus_data_out);
                    else m_ovf = 1'b1;
                end else if (off == 8'd1) begin
                    if (io_bus_data_out[3]) m_ovf = 1'b0;
                end else begin
                    m_div = io_bus_data_out;
                end
            end
        end
    endtask

    always @(posedge clock) model_step();

    function automatic logic [7:0] exp_read();
        logic [7:0] off;
        logic [7:0] r;
        off = io_bus_address - BASE;
        r   = 8'h00;
        if (io_bus_in === 1'b1 && off < 8'd3) begin
            if (off == 8'd1) begin
                r = {4'b0000, m_ovf, (m_active ? 1'b1 : 1'b0),
                     ((mq.size() == DEPTH) ? 1'b1 : 1'b0), ((mq.size() == 0) ? 1'b1 : 1'b0)};
            end else if (off == 8'd2) begin
                r = m_div;
            end
        end
        return r;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("line", {7'b0, uart_tx}, {7'b0, m_line});
            check("rdata", io_read_data, exp_read());
        end
    end

    // Simple frame counter: a low sample while idle marks a start bit, then skip the frame.
    int rx_period = 1;
    int rx_frames = 0;
    int rx_skip   = 0;
    always @(negedge clock) begin
        if (rx_skip > 0) rx_skip <= rx_skip - 1;
        else if (m_valid && uart_tx === 1'b0) begin
            rx_frames <= rx_frames + 1;
            rx_skip   <= rx_period * 10 - 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_bus_address  = a;
        io_bus_data_out = d;
        io_bus_out      = 1'b1;
        @(posedge clock); #1;
        io_bus_out      = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        io_bus_address = a;
        io_bus_in      = 1'b1;
        #2;
        check(name, io_read_data, exp);
        @(posedge clock); #1;
        io_bus_in      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic        trace [0:127];
    logic [9:0]  a5_pat;
    int          dk [15];
    logic [14:0] dv;
    int          f0;
    int          zeros;
    int          r;
    int          w;

    initial begin
        reset_n = 1'b0; clock_enable = 1'b0; io_bus_out = 1'b0; io_bus_in = 1'b0;
        io_bus_address = 8'h00; io_bus_data_out = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1; clock_enable = 1'b1;

        // Reset state
        check("rst_line", {7'b0, uart_tx}, 8'h01);
        rd_check("rst_status", BASE + 8'd1, 8'h01);
        rd_check("rst_divisor", BASE + 8'd2, 8'h0F);

        // Single byte A5 at one clock per bit
        wr(BASE + 8'd2, 8'h00);
        wr(BASE, 8'hA5);
        trace[0] = uart_tx;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock); #1;
            trace[k] = uart_tx;
        end
        a5_pat = 10'b1101001010;
        check("a5_before_start", {7'b0, trace[0]}, 8'h01);
        for (int k = 1; k <= 10; k++) check("a5_bit", {7'b0, trace[k]}, {7'b0, a5_pat[k-1]});
        check("a5_idle", {7'b0, trace[11]}, 8'h01);
        rd_check("a5_status", BASE + 8'd1, 8'h01);

        // Fill and overflow
        rx_period = 16;
        wr(BASE + 8'd2, 8'd15);
        f0 = rx_frames;
        for (int i = 0; i < 6; i++) wr(BASE, 8'h30 + 8'(i));
        rd_check("ovf_status", BASE + 8'd1, 8'h0E);
        wr(BASE + 8'd1, 8'h08);
        rd_check("ovf_cleared", BASE + 8'd1, 8'h06);
        idle(5 * 161 + 20);
        check("frames_emitted", 8'(rx_frames - f0), 8'd5);
        rd_check("ovf_drained", BASE + 8'd1, 8'h01);

        // Push aligned with the IDLE pop while full
        for (int i = 0; i < 5; i++) wr(BASE, 8'hC0 + 8'(i));
        idle(157);
        wr(BASE, 8'hEE);
        rd_check("pushpop_status", BASE + 8'd1, 8'h06);
        idle(6 * 161);
        rd_check("pushpop_drained", BASE + 8'd1, 8'h01);

        // Divisor change during data bit 3
        wr(BASE, 8'hA8);
        wr(BASE, 8'h00);
        for (int k = 2; k <= 106; k++) begin
            if (k == 70) begin
                io_bus_address = BASE + 8'd2; io_bus_data_out = 8'd3; io_bus_out = 1'b1;
            end else begin
                io_bus_out = 1'b0;
            end
            @(posedge clock); #1;
            trace[k] = uart_tx;
        end
        io_bus_out = 1'b0;
        dk = '{64, 65, 80, 81, 84, 85, 88, 89, 92, 93, 100, 101, 102, 105, 106};
        dv = 15'b000111001100110;
        for (int i = 0; i < 15; i++) check("divchg_line", {7'b0, trace[dk[i]]}, {7'b0, dv[i]});
        idle(60);
        rd_check("divchg_divisor", BASE + 8'd2, 8'h03);

        // Reset during data bit 2
        wr(BASE + 8'd2, 8'd7);
        wr(BASE, 8'hA8);
        wr(BASE, 8'h55);
        idle(26);
        check("pre_reset_line", {7'b0, uart_tx}, 8'h00);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("reset_line", {7'b0, uart_tx}, 8'h01);
        reset_n = 1'b1;
        rd_check("reset_status", BASE + 8'd1, 8'h01);
        rd_check("reset_divisor", BASE + 8'd2, 8'h0F);
        zeros = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clock); #1;
            if (uart_tx !== 1'b1) zeros++;
        end
        check("no_frames_after_reset", 8'(zeros), 8'd0);

        // Randomized bus traffic
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            clock_enable    = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
            io_bus_out      = 1'b0;
            io_bus_data_out = 8'($urandom);
            if (r < 15) begin
                io_bus_out = 1'b1; io_bus_address = BASE;
            end else if (r < 19) begin
                io_bus_out = 1'b1; io_bus_address = BASE + 8'd2;
                io_bus_data_out = 8'($urandom_range(0, 3));
            end else if (r < 23) begin
                io_bus_out = 1'b1; io_bus_address = BASE + 8'd1;
            end else if (r < 27) begin
                io_bus_out = 1'b1;
                io_bus_address = ($urandom_range(0, 1) == 0) ? BASE - 8'd1 : BASE + 8'd3;
            end else begin
                io_bus_address = BASE - 8'd2 + 8'($urandom_range(0, 5));
            end
            io_bus_in = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            @(posedge clock); #1;
        end
        io_bus_out = 1'b0; io_bus_in = 1'b0; clock_enable = 1'b1;
        w = 0;
        while ((mq.size() > 0 || m_active) && w < 6000) begin
            idle(1);
            w++;
        end
        check("random_drain", ((mq.size() > 0 || m_active) ? 8'h01 : 8'h00), 8'h00);
        wr(BASE + 8'd1, 8'h08);
        rd_check("final_status", BASE + 8'd1, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
